// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//   Sequences the program counter and the instruction-memory fetch port.
//   Keeps at most one imem request in flight and hands each fetched word to
//   decode over a valid/ready handshake. Trap and branch redirects rewrite the
//   PC in the same cycle they are presented (trap wins). A response that was
//   already in flight when a redirect arrived is squashed.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   pc_i                          current PC held by the external PC register
//   pc_wr_en_o / pc_wr_dat_o      load the PC (word aligned)
//   pc_stall_o                    1 = hold PC; 0 (without a load) = PC + 4
//   trap_vld_i / trap_tgt_i       trap redirect, highest priority
//   br_vld_i / br_tgt_i           branch/jump redirect from execute
//   imem_req_o / imem_addr_o      fetch request and address (address = pc_i)
//   imem_gnt_i                    request accepted this cycle
//   imem_rvalid_i / imem_rdata_i  response, one per grant, at least 1 cycle later
//   if_valid_o / if_instr_o       instruction to decode
//   if_pc_o                       PC of if_instr_o
//   if_ready_i                    decode accepts the instruction
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter int unsigned        width_p     = 32,
  parameter logic [width_p-1:0] reset_vec_p = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [width_p-1:0] pc_i,
  output logic               pc_wr_en_o,
  output logic [width_p-1:0] pc_wr_dat_o,
  output logic               pc_stall_o,
  input  logic               trap_vld_i,
  input  logic [width_p-1:0] trap_tgt_i,
  input  logic               br_vld_i,
  input  logic [width_p-1:0] br_tgt_i,
  output logic               imem_req_o,
  output logic [width_p-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [width_p-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [width_p-1:0] if_instr_o,
  output logic [width_p-1:0] if_pc_o,
  input  logic               if_ready_i
);

  localparam logic [width_p-1:0] AlignMask = {{(width_p-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_e;

  state_e             state_q;
  logic               squash_q;
  // BOOT spends one cycle arming and one cycle writing the boot vector, so the
  // PC-write output stays at its reset value (0) while reset is asserted.
  logic               boot_wr_q;
  logic [width_p-1:0] fetch_pc_q;
  logic [width_p-1:0] instr_q;
  logic [width_p-1:0] ipc_q;

  logic               redir;
  logic               advance;
  logic [width_p-1:0] tgt;

  always_comb begin
    redir   = (trap_vld_i | br_vld_i) & (state_q != BOOT);
    tgt     = trap_vld_i ? trap_tgt_i : br_tgt_i;
    // A redirect in VALID drops the instruction, so it must also block PC+4.
    advance = (state_q == VALID) & if_ready_i & ~redir;
  end

  assign pc_wr_en_o  = boot_wr_q | redir;
  assign pc_wr_dat_o = redir     ? (tgt & AlignMask) :
                       boot_wr_q ? (reset_vec_p & AlignMask) : '0;
  assign pc_stall_o  = ~advance;

  assign imem_req_o  = (state_q == REQ);
  assign imem_addr_o = pc_i;
  assign if_valid_o  = (state_q == VALID);
  assign if_instr_o  = instr_q;
  assign if_pc_o     = ipc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      squash_q   <= 1'b0;
      boot_wr_q  <= 1'b0;
      fetch_pc_q <= '0;
      instr_q    <= '0;
      ipc_q      <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          if (!boot_wr_q) begin
            boot_wr_q <= 1'b1;
          end else begin
            boot_wr_q <= 1'b0;
            state_q   <= REQ;
          end
        end
        REQ: begin
          // A grant coinciding with a redirect accepted the old address; its
          // response must be thrown away.
          if (imem_gnt_i) begin
            fetch_pc_q <= pc_i;
            squash_q   <= redir;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            squash_q <= 1'b0;
            if (squash_q || redir) begin
              state_q <= REQ;
            end else begin
              instr_q <= imem_rdata_i;
              ipc_q   <= fetch_pc_q;
              state_q <= VALID;
            end
          end else if (redir) begin
            squash_q <= 1'b1;
          end
        end
        VALID: begin
          if (redir || if_ready_i) begin
            state_q <= REQ;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// -----------------------------------------------------------------------------
// tb_fetch_controller
//   Environment: an external PC register, a randomised single-outstanding
//   instruction memory and a random decode stage. The memory returns
//   mem_word(addr) so every delivered instruction can be tied to its PC.
//   Reference model: the program-order PC stream (boot vector, +4 per accepted
//   instruction, aligned target on every redirect) and a queue of expected PC
//   writes filled when redirects are issued.
// -----------------------------------------------------------------------------
module tb_fetch_controller;

  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [W-1:0]  pc_i;
  logic          pc_wr_en_o;
  logic [W-1:0]  pc_wr_dat_o;
  logic          pc_stall_o;
  logic          trap_vld_i;
  logic [W-1:0]  trap_tgt_i;
  logic          br_vld_i;
  logic [W-1:0]  br_tgt_i;
  logic          imem_req_o;
  logic [W-1:0]  imem_addr_o;
  logic          imem_gnt_i;
  logic          imem_rvalid_i;
  logic [W-1:0]  imem_rdata_i;
  logic          if_valid_o;
  logic [W-1:0]  if_instr_o;
  logic [W-1:0]  if_pc_o;
  logic          if_ready_i;

  always #5 clk = ~clk;

  fetch_controller #(.width_p(W), .reset_vec_p(RV)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pc_i(pc_i),
    .pc_wr_en_o(pc_wr_en_o), .pc_wr_dat_o(pc_wr_dat_o), .pc_stall_o(pc_stall_o),
    .trap_vld_i(trap_vld_i), .trap_tgt_i(trap_tgt_i),
    .br_vld_i(br_vld_i), .br_tgt_i(br_tgt_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
    .if_ready_i(if_ready_i)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Environment knobs, written by the main sequence at negedges.
  int          gnt_pct = 100, ready_pct = 100, redir_pct = 0;
  int          lat_min = 1, lat_max = 1;
  int          guard = 0;
  bit          shot = 0, shot_tv = 0, shot_bv = 0;
  logic [31:0] shot_t = '0, shot_b = '0;

  // Memory state.
  bit          outstanding = 0;
  int          cnt = 0;
  logic [31:0] resp_addr = '0;

  // Reference model.
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_pc = RV;
  int          n_acc = 0;
  logic [31:0] last_acc_pc = '0;
  bit          tp_mode = 0;
  int          cyc = 0;
  int          last_acc_cyc = -1;

  // Environment: PC register, memory responder, decode, redirect stimulus.
  initial begin
    logic        c_wr, c_stall, c_hs, c_rv;
    logic [31:0] c_dat, c_addr;
    pc_i = 32'hDEAD_BEE0;
    trap_vld_i = 0; br_vld_i = 0; trap_tgt_i = '0; br_tgt_i = '0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0; if_ready_i = 0;
    forever begin
      @(negedge clk);
      c_wr = pc_wr_en_o; c_dat = pc_wr_dat_o; c_stall = pc_stall_o;
      c_hs = imem_req_o && imem_gnt_i && rst_ni; c_addr = imem_addr_o;
      c_rv = imem_rvalid_i;
      @(posedge clk);
      #1;
      if (c_wr) pc_i = c_dat;
      else if (!c_stall) pc_i = pc_i + 32'd4;
      if (c_rv) outstanding = 0;
      if (c_hs) begin
        outstanding = 1;
        cnt = $urandom_range(lat_max, lat_min) - 1;
        resp_addr = c_addr;
      end
      imem_rvalid_i = 0;
      imem_rdata_i = $urandom;
      if (outstanding) begin
        if (cnt == 0) begin
          imem_rvalid_i = 1;
          imem_rdata_i = mem_word(resp_addr);
        end else begin
          cnt--;
        end
      end
      imem_gnt_i = !outstanding && ($urandom_range(99, 0) < gnt_pct);
      if_ready_i = ($urandom_range(99, 0) < ready_pct);
      trap_vld_i = 0; br_vld_i = 0;
      trap_tgt_i = $urandom; br_tgt_i = $urandom;
      if (guard > 0) begin
        guard--;
      end else if (shot) begin
        trap_vld_i = shot_tv; br_vld_i = shot_bv;
        trap_tgt_i = shot_t;  br_tgt_i = shot_b;
        shot = 0;
      end else if ($urandom_range(99, 0) < redir_pct) begin
        trap_vld_i = $urandom_range(1, 0);
        br_vld_i = $urandom_range(1, 0);
        if (!trap_vld_i && !br_vld_i) br_vld_i = 1;
      end
      if (trap_vld_i || br_vld_i)
        exp_wr_q.push_back((trap_vld_i ? trap_tgt_i : br_tgt_i) & 32'hFFFF_FFFC);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        redir;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) continue;
      redir = trap_vld_i || br_vld_i;
      if (redir) check("pc_wr_en_on_redirect", pc_wr_en_o, 1);
      if (pc_wr_en_o) begin
        if (exp_wr_q.size() == 0) begin
          check("pc_wr_unexpected", pc_wr_en_o, 0);
        end else begin
          e = exp_wr_q.pop_front();
          check("pc_wr_dat", pc_wr_dat_o, e);
        end
        check("stall_with_wr", pc_stall_o, 1);
      end else begin
        check("pc_stall", pc_stall_o, !(if_valid_o && if_ready_i && !redir));
      end
      if (imem_req_o) check("imem_addr", imem_addr_o, pc_i);
      if (if_valid_o) begin
        check("if_pc", if_pc_o, exp_pc);
        check("if_instr", if_instr_o, mem_word(exp_pc));
        check("no_req_in_valid", imem_req_o, 0);
      end
      if (if_valid_o && if_ready_i && !redir) begin
        if (tp_mode && last_acc_cyc >= 0) check("throughput", cyc - last_acc_cyc, 3);
        last_acc_cyc = cyc;
        last_acc_pc = if_pc_o;
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end
      if (redir) exp_pc = (trap_vld_i ? trap_tgt_i : br_tgt_i) & ~32'h3;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, if_valid_o, 0);
    check({tag, "_req"}, imem_req_o, 0);
    check({tag, "_wr_en"}, pc_wr_en_o, 0);
    check({tag, "_wr_dat"}, pc_wr_dat_o, 0);
    check({tag, "_stall"}, pc_stall_o, 1);
    check({tag, "_instr"}, if_instr_o, 0);
    check({tag, "_pc"}, if_pc_o, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    exp_pc = RV;
    exp_wr_q.delete();
    exp_wr_q.push_back(RV);
    guard = 4;
    rst_ni = 1;
  endtask

  task automatic wait_in_wait(input string name, output bit ok);
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (outstanding && !imem_rvalid_i && cnt >= 1) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_accept(input string name, input logic [31:0] want_pc);
    int n0;
    bit ok;
    @(negedge clk);
    n0 = n_acc;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (n_acc > n0) begin ok = 1; break; end
    end
    check({name, "_delivered"}, ok, 1);
    if (ok) check({name, "_pc"}, last_acc_pc, want_pc);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");

    // Boot and back-to-back fetches at minimum latency.
    tp_mode = 1;
    release_reset();
    repeat (16) @(negedge clk);
    tp_mode = 0;
    check("boot_fetches", n_acc >= 3, 1);

    // Decode stalls for several cycles.
    ready_pct = 0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (if_valid_o) begin ok = 1; break; end
    end
    check("hold_valid_seen", ok, 1);
    repeat (5) @(negedge clk);
    ready_pct = 100;

    // Branch while waiting for a response.
    lat_min = 3; lat_max = 3;
    wait_in_wait("br_wait_reach", ok);
    if (ok) begin
      shot_tv = 0; shot_bv = 1; shot_b = 32'h100; shot = 1;
      wait_accept("br_wait", 32'h100);
    end

    // Trap and branch in the same cycle: trap wins.
    wait_in_wait("trap_br_reach", ok);
    if (ok) begin
      shot_tv = 1; shot_t = 32'h80; shot_bv = 1; shot_b = 32'h200; shot = 1;
      wait_accept("trap_br", 32'h80);
    end

    // Redirect coincident with a grant, unaligned target.
    lat_min = 1; lat_max = 1; gnt_pct = 100; ready_pct = 100;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (if_valid_o && if_ready_i) begin ok = 1; break; end
    end
    check("gnt_redir_reach", ok, 1);
    if (ok) begin
      shot_tv = 0; shot_bv = 1; shot_b = 32'h103; shot = 1;
      wait_accept("gnt_redir", 32'h100);
    end

    // Random traffic.
    gnt_pct = 60; ready_pct = 60; redir_pct = 8; lat_min = 1; lat_max = 4;
    repeat (1500) @(negedge clk);
    redir_pct = 0;
    repeat (2) @(negedge clk);
    check("wr_queue_drained", exp_wr_q.size(), 0);

    // Reset in the middle of WAIT with a response still on its way.
    gnt_pct = 100; ready_pct = 100; lat_min = 5; lat_max = 5;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (outstanding && !imem_rvalid_i && cnt == 2) begin ok = 1; break; end
    end
    check("mid_wait_reach", ok, 1);
    rst_ni = 0;
    #1;
    check_reset_outputs("async_rst");
    release_reset();
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_valid", if_valid_o, 0);
    end

    gnt_pct = 70; ready_pct = 70; redir_pct = 5;
    repeat (300) @(negedge clk);
    redir_pct = 0;
    repeat (20) @(negedge clk);
    check("final_wr_queue", exp_wr_q.size(), 0);
    check("enough_deliveries", n_acc > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
